// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared operation encodings for the RV64 execute stage
package exec_pkg;

  // ALU operation select, one-hot; is_word narrows add/sub/shifts to 32 bits
  typedef struct packed {
    logic add;
    logic sub;
    logic sll;
    logic slt;
    logic sltu;
    logic xor_op;
    logic srl;
    logic sra;
    logic or_op;
    logic and_op;
    logic lui;
    logic auipc;
    logic is_word;
  } alu_ops_t;

  // Memory access kind, zero meaning no access; carried through to the memory stage
  typedef struct packed {
    logic [3:0] load_op;
    logic [3:0] store_op;
  } io_ops_t;

  // Branch and jump select, one-hot
  typedef struct packed {
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
    logic jal;
    logic jalr;
  } bj_ops_t;

  // Environment call / breakpoint select
  typedef struct packed {
    logic ecall;
    logic ebreak;
  } sys_ops_t;

  // Return-address increments for compressed and full-length instructions
  localparam logic [63:0] LINK_INC2 = 64'd2;
  localparam logic [63:0] LINK_INC4 = 64'd4;

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - purely combinational RV64 ALU
module exec_alu
  import exec_pkg::*;
(
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic [63:0] pc,
  input  alu_ops_t    alu_ops,
  output logic [63:0] result
);

  logic [63:0] sum_d;
  logic [63:0] diff_d;
  logic [63:0] sll_d;
  logic [63:0] srl_d;
  logic [63:0] sra_d;
  logic [31:0] sll_w;
  logic [31:0] srl_w;
  logic [31:0] sra_w;
  logic        word_capable;

  assign sum_d  = op_a + op_b;
  assign diff_d = op_a - op_b;
  assign sll_d  = op_a << op_b[5:0];
  assign srl_d  = op_a >> op_b[5:0];
  assign sra_d  = $signed(op_a) >>> op_b[5:0];
  assign sll_w  = op_a[31:0] << op_b[4:0];
  assign srl_w  = op_a[31:0] >> op_b[4:0];
  assign sra_w  = $signed(op_a[31:0]) >>> op_b[4:0];

  // Only add/sub/shifts have word forms; is_word on other ops is ignored
  assign word_capable = alu_ops.is_word &
                        (alu_ops.add | alu_ops.sub | alu_ops.sll | alu_ops.srl | alu_ops.sra);

  // Select the operation result; an empty op vector falls back to add
  always_comb begin
    result = sum_d;
    if (word_capable) begin
      if (alu_ops.sub)      result = {{32{diff_d[31]}}, diff_d[31:0]};
      else if (alu_ops.sll) result = {{32{sll_w[31]}}, sll_w};
      else if (alu_ops.srl) result = {{32{srl_w[31]}}, srl_w};
      else if (alu_ops.sra) result = {{32{sra_w[31]}}, sra_w};
      else                  result = {{32{sum_d[31]}}, sum_d[31:0]};
    end else begin
      if (alu_ops.sub)         result = diff_d;
      else if (alu_ops.sll)    result = sll_d;
      else if (alu_ops.slt)    result = {63'd0, $signed(op_a) < $signed(op_b)};
      else if (alu_ops.sltu)   result = {63'd0, op_a < op_b};
      else if (alu_ops.xor_op) result = op_a ^ op_b;
      else if (alu_ops.srl)    result = srl_d;
      else if (alu_ops.sra)    result = sra_d;
      else if (alu_ops.or_op)  result = op_a | op_b;
      else if (alu_ops.and_op) result = op_a & op_b;
      else if (alu_ops.lui)    result = op_b;
      else if (alu_ops.auipc)  result = pc + op_b;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - RV64 execute stage with branch resolution, trap request and EX/MA register
module exec_stage
  import exec_pkg::*;
#(
  parameter logic [63:0] TRAP_VECTOR = 64'h0000_0000_8000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        stall,
  input  alu_ops_t    alu_ops,
  input  io_ops_t     io_ops,
  input  bj_ops_t     bj_ops,
  input  sys_ops_t    sys_ops,
  input  logic        compressed,
  input  logic [63:0] pc,
  input  logic [4:0]  rd,
  input  logic [63:0] imm,
  input  logic        with_imm,
  input  logic [63:0] fwd1,
  input  logic [63:0] fwd2,
  output logic [63:0] trap_pc,
  output logic        trap_en,
  output logic [63:0] bj_pc,
  output logic        bj_en,
  output io_ops_t     io_ops_out,
  output logic [63:0] pc_out,
  output logic [4:0]  rd_out,
  output logic [63:0] result_out,
  output logic [63:0] data2_out
);

  logic [63:0] op_b;
  logic [63:0] alu_res;
  logic [63:0] link;
  logic [63:0] jalr_target;
  logic [63:0] rel_target;
  logic [63:0] result_next;
  logic        taken;
  logic        is_jump;
  logic        is_sys;
  logic        io_active;

  assign op_b = with_imm ? imm : fwd2;

  exec_alu u_alu (
    .op_a    (fwd1),
    .op_b    (op_b),
    .pc      (pc),
    .alu_ops (alu_ops),
    .result  (alu_res)
  );

  // Branches always compare the two register values, never the immediate
  assign taken = (bj_ops.beq  & (fwd1 == fwd2)) |
                 (bj_ops.bne  & (fwd1 != fwd2)) |
                 (bj_ops.blt  & ($signed(fwd1) <  $signed(fwd2))) |
                 (bj_ops.bge  & ($signed(fwd1) >= $signed(fwd2))) |
                 (bj_ops.bltu & (fwd1 <  fwd2)) |
                 (bj_ops.bgeu & (fwd1 >= fwd2));

  assign is_jump     = bj_ops.jal | bj_ops.jalr;
  assign is_sys      = sys_ops.ecall | sys_ops.ebreak;
  assign io_active   = |{io_ops.load_op, io_ops.store_op};
  assign rel_target  = pc + imm;
  assign jalr_target = (fwd1 + imm) & ~64'h1;
  assign link        = pc + (compressed ? LINK_INC2 : LINK_INC4);

  // A stalled instruction has not really executed yet, so it must not redirect or trap
  assign bj_en   = (taken | is_jump) & ~stall;
  assign bj_pc   = bj_en ? (bj_ops.jalr ? jalr_target : rel_target) : 64'd0;
  assign trap_en = is_sys & ~stall;
  assign trap_pc = trap_en ? TRAP_VECTOR : 64'd0;

  // Pick what the memory stage sees as result: link address, memory address or ALU value
  always_comb begin
    result_next = alu_res;
    if (io_active) result_next = fwd1 + imm;
    if (is_jump)   result_next = link;
  end

  // EX/MA register: clear beats stall; traps retire with no writeback and no memory access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_ops_out <= '0;
      pc_out     <= '0;
      rd_out     <= '0;
      result_out <= '0;
      data2_out  <= '0;
    end else if (clear) begin
      io_ops_out <= '0;
      pc_out     <= '0;
      rd_out     <= '0;
      result_out <= '0;
      data2_out  <= '0;
    end else if (!stall) begin
      io_ops_out <= is_sys ? '0 : io_ops;
      pc_out     <= pc;
      rd_out     <= is_sys ? 5'd0 : rd;
      result_out <= result_next;
      data2_out  <= fwd2;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - scoreboard bench for exec_stage against a behavioural model
module tb_exec_stage;
  import exec_pkg::*;

  localparam logic [63:0] TVEC = 64'h0000_0000_8000_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear, stall, compressed, with_imm;
  alu_ops_t    alu_ops;
  io_ops_t     io_ops;
  bj_ops_t     bj_ops;
  sys_ops_t    sys_ops;
  logic [63:0] pc, imm, fwd1, fwd2;
  logic [4:0]  rd;
  logic [63:0] trap_pc, bj_pc, pc_out, result_out, data2_out;
  logic        trap_en, bj_en;
  io_ops_t     io_ops_out;
  logic [4:0]  rd_out;

  exec_stage #(.TRAP_VECTOR(TVEC)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stall(stall),
    .alu_ops(alu_ops), .io_ops(io_ops), .bj_ops(bj_ops), .sys_ops(sys_ops),
    .compressed(compressed), .pc(pc), .rd(rd), .imm(imm), .with_imm(with_imm),
    .fwd1(fwd1), .fwd2(fwd2), .trap_pc(trap_pc), .trap_en(trap_en),
    .bj_pc(bj_pc), .bj_en(bj_en), .io_ops_out(io_ops_out), .pc_out(pc_out),
    .rd_out(rd_out), .result_out(result_out), .data2_out(data2_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bj_en;
    logic [63:0] bj_pc;
    logic        chk_bj_pc;
    logic        trap_en;
    logic [63:0] trap_pc;
    io_ops_t     io;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] result;
    logic [63:0] data2;
  } exp_t;

  exp_t sb[$];

  // Model of the EX/MA register contents
  io_ops_t     m_io;
  logic [63:0] m_pc, m_result, m_data2;
  logic [4:0]  m_rd;

  int n_checks = 0;
  int n_fail = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Result computed straight from the instruction semantics
  function automatic logic [63:0] ref_result();
    logic [63:0] a, b;
    logic [31:0] aw;
    int sh;
    a  = fwd1;
    b  = with_imm ? imm : fwd2;
    aw = a[31:0];
    if (bj_ops.jal || bj_ops.jalr) return pc + (compressed ? 64'd2 : 64'd4);
    if (io_ops.load_op != 0 || io_ops.store_op != 0) return fwd1 + imm;
    if (alu_ops.is_word && (alu_ops.add || alu_ops.sub || alu_ops.sll || alu_ops.srl || alu_ops.sra)) begin
      sh = int'(b[4:0]);
      if (alu_ops.sub) return sx32(aw - b[31:0]);
      if (alu_ops.sll) return sx32(aw << sh);
      if (alu_ops.srl) return sx32(aw >> sh);
      if (alu_ops.sra) return sx32($signed(aw) >>> sh);
      return sx32(aw + b[31:0]);
    end
    sh = int'(b[5:0]);
    if (alu_ops.sub)    return a - b;
    if (alu_ops.sll)    return a << sh;
    if (alu_ops.slt)    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    if (alu_ops.sltu)   return (a < b) ? 64'd1 : 64'd0;
    if (alu_ops.xor_op) return a ^ b;
    if (alu_ops.srl)    return a >> sh;
    if (alu_ops.sra)    return $signed(a) >>> sh;
    if (alu_ops.or_op)  return a | b;
    if (alu_ops.and_op) return a & b;
    if (alu_ops.lui)    return imm;
    if (alu_ops.auipc)  return pc + imm;
    return a + b;
  endfunction

  // Record expectations for this cycle, then advance the register model past the next edge
  task automatic step();
    exp_t e;
    logic tk, sys;
    tk = (bj_ops.beq && fwd1 == fwd2) || (bj_ops.bne && fwd1 != fwd2) ||
         (bj_ops.blt && $signed(fwd1) < $signed(fwd2)) ||
         (bj_ops.bge && $signed(fwd1) >= $signed(fwd2)) ||
         (bj_ops.bltu && fwd1 < fwd2) || (bj_ops.bgeu && fwd1 >= fwd2) ||
         bj_ops.jal || bj_ops.jalr;
    sys = sys_ops.ecall || sys_ops.ebreak;
    if (!rst_n) begin
      m_io = '0; m_pc = 0; m_rd = 0; m_result = 0; m_data2 = 0;
    end
    e.bj_en     = tk && !stall;
    e.bj_pc     = !tk ? 64'd0 : bj_ops.jalr ? ((fwd1 + imm) & ~64'h1) : pc + imm;
    e.chk_bj_pc = !stall;
    e.trap_en   = sys && !stall;
    e.trap_pc   = (sys && !stall) ? TVEC : 64'd0;
    e.io = m_io; e.pc = m_pc; e.rd = m_rd; e.result = m_result; e.data2 = m_data2;
    sb.push_back(e);
    if (!rst_n || clear) begin
      m_io = '0; m_pc = 0; m_rd = 0; m_result = 0; m_data2 = 0;
    end else if (!stall) begin
      m_io     = sys ? io_ops_t'(8'd0) : io_ops;
      m_pc     = pc;
      m_rd     = sys ? 5'd0 : rd;
      m_result = ref_result();
      m_data2  = fwd2;
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1; clear = 1'b0; stall = 1'b0; compressed = 1'b0; with_imm = 1'b0;
    alu_ops = '0; io_ops = '0; bj_ops = '0; sys_ops = '0;
    pc = 0; rd = 0; imm = 0; fwd1 = 0; fwd2 = 0;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic randomize_inputs();
    int cat, k;
    fwd1 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : r64();
    fwd2 = ($urandom_range(0, 3) == 0) ? fwd1 : r64();
    imm  = ($urandom_range(0, 1) == 0) ? 64'($signed($urandom_range(0, 4095)) - 2048) : r64();
    pc   = {32'd0, $urandom} & ~64'h1;
    rd   = 5'($urandom);
    with_imm   = 1'($urandom);
    compressed = 1'($urandom);
    cat = $urandom_range(0, 5);
    if (cat <= 1) begin
      k = $urandom_range(0, 11);
      alu_ops = alu_ops_t'(13'd1 << (k + 1));
      alu_ops.is_word = 1'($urandom);
      if (alu_ops.lui || alu_ops.auipc) with_imm = 1'b1;
    end else if (cat == 2) begin
      if ($urandom_range(0, 1) == 0) io_ops.load_op = 4'($urandom_range(1, 15));
      else io_ops.store_op = 4'($urandom_range(1, 15));
    end else if (cat == 3) begin
      bj_ops = bj_ops_t'(8'd1 << $urandom_range(2, 7));
    end else if (cat == 4) begin
      bj_ops = bj_ops_t'(8'd1 << $urandom_range(0, 1));
    end else begin
      sys_ops = sys_ops_t'(2'd1 << $urandom_range(0, 1));
    end
    stall = ($urandom_range(0, 9) == 0);
    clear = ($urandom_range(0, 19) == 0);
  endtask

  // Monitor: compare every presented output against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bj_en", 64'(bj_en), 64'(e.bj_en));
        if (e.chk_bj_pc) chk("bj_pc", bj_pc, e.bj_pc);
        chk("trap_en", 64'(trap_en), 64'(e.trap_en));
        chk("trap_pc", trap_pc, e.trap_pc);
        chk("io_ops_out", 64'(io_ops_out), 64'(e.io));
        chk("pc_out", pc_out, e.pc);
        chk("rd_out", 64'(rd_out), 64'(e.rd));
        chk("result_out", result_out, e.result);
        chk("data2_out", data2_out, e.data2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    m_io = '0; m_pc = 0; m_rd = 0; m_result = 0; m_data2 = 0;
    clear = 0; stall = 0; compressed = 0; with_imm = 0;
    alu_ops = '0; io_ops = '0; bj_ops = '0; sys_ops = '0;
    pc = 0; rd = 0; imm = 0; fwd1 = 0; fwd2 = 0;
    #1;
    chk("reset_result", result_out, 64'd0);
    chk("reset_rd", 64'(rd_out), 64'd0);
    for (int i = 0; i < 2; i++) begin
      begin_cycle(); rst_n = 1'b0; step();
    end

    // addi x3, 5 + 7
    begin_cycle(); fwd1 = 5; imm = 7; with_imm = 1; rd = 3; alu_ops.add = 1; step();
    // sub.w 0 - 1
    begin_cycle(); fwd1 = 0; fwd2 = 1; alu_ops.sub = 1; alu_ops.is_word = 1; step();
    @(negedge clk); #1;
    chk("addi_rd", 64'(rd_out), 64'd3);
    chk("addi_result", result_out, 64'd12);
    // beq taken
    begin_cycle(); fwd1 = 9; fwd2 = 9; pc = 64'h1000; imm = 64'h20; bj_ops.beq = 1; step();
    #1;
    chk("beq_taken_en", 64'(bj_en), 64'd1);
    chk("beq_taken_pc", bj_pc, 64'h1020);
    @(negedge clk); #1;
    chk("subw_result", result_out, 64'hFFFF_FFFF_FFFF_FFFF);
    // beq not taken
    begin_cycle(); fwd1 = 9; fwd2 = 8; pc = 64'h1000; imm = 64'h20; bj_ops.beq = 1; step();
    #1;
    chk("beq_nt_en", 64'(bj_en), 64'd0);
    chk("beq_nt_pc", bj_pc, 64'd0);
    // compressed jalr
    begin_cycle(); pc = 64'h2000; fwd1 = 64'h3001; imm = 0; compressed = 1; rd = 1;
    bj_ops.jalr = 1; step();
    #1;
    chk("jalr_pc", bj_pc, 64'h3000);
    // store
    begin_cycle(); fwd1 = 64'h100; imm = 8; with_imm = 1; fwd2 = 64'hAB; io_ops.store_op = 3; step();
    @(negedge clk); #1;
    chk("jalr_link", result_out, 64'h2002);
    // stalled jal: no redirect, register keeps the store
    begin_cycle(); stall = 1; bj_ops.jal = 1; pc = 64'h40; imm = 64'h10; step();
    #1;
    chk("stall_mask_bj", 64'(bj_en), 64'd0);
    @(negedge clk); #1;
    chk("store_addr", result_out, 64'h108);
    chk("store_data", data2_out, 64'hAB);
    chk("store_op", 64'(io_ops_out.store_op), 64'd3);
    begin_cycle(); stall = 1; sys_ops.ebreak = 1; step();
    #1;
    chk("stall_mask_trap", 64'(trap_en), 64'd0);
    @(negedge clk); #1;
    chk("stall_hold", result_out, 64'h108);
    // ecall with a destination and a load op that must both be dropped
    begin_cycle(); sys_ops.ecall = 1; rd = 7; io_ops.load_op = 2; step();
    #1;
    chk("ecall_trap_en", 64'(trap_en), 64'd1);
    chk("ecall_trap_pc", trap_pc, TVEC);
    begin_cycle(); clear = 1; fwd1 = 64'h55; rd = 9; step();
    @(negedge clk); #1;
    chk("ecall_rd", 64'(rd_out), 64'd0);
    chk("ecall_io", 64'(io_ops_out), 64'd0);
    begin_cycle(); step();
    @(negedge clk); #1;
    chk("clear_result", result_out, 64'd0);
    chk("clear_pc", pc_out, 64'd0);

    // Randomized traffic with occasional stall, clear and asynchronous reset
    for (int i = 0; i < 600; i++) begin
      begin_cycle();
      randomize_inputs();
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset", result_out | pc_out | data2_out, 64'd0);
      end
      step();
    end

    begin_cycle(); step();
    @(negedge clk); #1;
    chk("queue_drained", 64'(sb.size()), 64'd0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
